// File: rtl/rv_bus_pkg.sv
// Shared bus definitions for the rv memory-mapped slaves: transaction
// states, slave-select width and latency counter width.
package rv_bus_pkg;

  localparam int SLAVE_SEL_WIDTH = 4;
  localparam int LAT_CNT_WIDTH   = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } bus_state_e;

endpackage

// File: rtl/rv_ram_be.sv
// Single-port 2**DEPTH_BIT x 32 RAM with per-byte write enables,
// synchronous write and registered (synchronous) read.
module rv_ram_be #(
  parameter int DEPTH_BIT = 10
) (
  input  logic                 i_clk,
  input  logic                 we,
  input  logic [3:0]           be,
  input  logic [DEPTH_BIT-1:0] addr,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata
);

  logic [31:0] mem [2**DEPTH_BIT];

  always_ff @(posedge i_clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we && be[b]) begin
        mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/rv_mem_slave.sv
// Bus slave wrapping a byte-enabled RAM: decodes the top address bits,
// waits a configurable latency, then acks reads and writes for one cycle.
module rv_mem_slave
  import rv_bus_pkg::*;
#(
  parameter logic [SLAVE_SEL_WIDTH-1:0] ADDR_HI = '0,
  parameter int DEPTH_BIT     = 10,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 1
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [31:0] i_addr,
  input  logic        i_read,
  input  logic        i_write,
  input  logic [3:0]  i_write_sel,
  input  logic [31:0] i_write_data,
  output logic [31:0] o_data,
  output logic        o_ack,
  output logic        o_busy
);

  localparam logic [LAT_CNT_WIDTH-1:0] RD_LOAD = LAT_CNT_WIDTH'(READ_LATENCY - 1);
  localparam logic [LAT_CNT_WIDTH-1:0] WR_LOAD = LAT_CNT_WIDTH'(WRITE_LATENCY - 1);

  bus_state_e               state, state_nxt;
  logic [LAT_CNT_WIDTH-1:0] cnt, cnt_nxt;
  logic                     primed, primed_nxt;
  logic                     ram_we;
  logic                     requesting;
  logic                     accept;

  logic [DEPTH_BIT-1:0]     addr_q;
  logic [31:0]              wdata_q;
  logic [3:0]               sel_q;
  logic                     wr_q;
  logic [31:0]              ram_rdata;
  logic                     unused_addr_bits;

  assign requesting = i_read | i_write;
  assign accept     = requesting && (i_addr[31-:SLAVE_SEL_WIDTH] == ADDR_HI);

  assign unused_addr_bits = ^{i_addr[31-SLAVE_SEL_WIDTH:DEPTH_BIT+2], i_addr[1:0]};

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state  <= IDLE;
      cnt    <= '0;
      primed <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      primed <= primed_nxt;
    end
  end

  // One settling WAIT cycle precedes the countdown, so the ack lands
  // LAT+1 cycles after the accepting edge.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    primed_nxt = primed;
    ram_we     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt  = WAIT;
          cnt_nxt    = i_write ? WR_LOAD : RD_LOAD;
          primed_nxt = 1'b0;
        end
      end
      WAIT: begin
        if (!requesting) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (!primed) begin
          primed_nxt = 1'b1;
        end else if (cnt == '0) begin
          state_nxt = ACK;
          ram_we    = wr_q && i_reset_n;
        end else begin
          cnt_nxt = cnt - LAT_CNT_WIDTH'(1);
        end
      end
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (state == IDLE && accept) begin
      addr_q  <= i_addr[DEPTH_BIT+1:2];
      wdata_q <= i_write_data;
      sel_q   <= i_write_sel;
      wr_q    <= i_write;
    end
  end

  rv_ram_be #(
    .DEPTH_BIT(DEPTH_BIT)
  ) u_ram (
    .i_clk (i_clk),
    .we    (ram_we),
    .be    (sel_q),
    .addr  (addr_q),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  assign o_ack  = (state == ACK);
  assign o_busy = (state != IDLE);
  assign o_data = (state == ACK && !wr_q) ? ram_rdata : 32'h0;

endmodule

// File: tb/tb_rv_mem_slave.sv
// Self-checking bench: three differently parameterised slaves driven with
// directed and random transactions, checked every cycle against a model.
module tb_rv_mem_slave;

  localparam int NI = 3;

  int hi_p  [NI] = '{0, 2, 0};
  int dep_p [NI] = '{10, 10, 4};
  int rl_p  [NI] = '{2, 4, 1};
  int wl_p  [NI] = '{1, 3, 2};

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr  [NI];
  logic [31:0] wdata [NI];
  logic [31:0] odata [NI];
  logic [3:0]  sel   [NI];
  logic        rd    [NI];
  logic        wr    [NI];
  logic        ack   [NI];
  logic        busy  [NI];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  rv_mem_slave #(.ADDR_HI(4'h0), .DEPTH_BIT(10), .READ_LATENCY(2), .WRITE_LATENCY(1)) dut0 (
    .i_clk(clk), .i_reset_n(rst_n), .i_addr(addr[0]), .i_read(rd[0]), .i_write(wr[0]),
    .i_write_sel(sel[0]), .i_write_data(wdata[0]), .o_data(odata[0]), .o_ack(ack[0]), .o_busy(busy[0]));

  rv_mem_slave #(.ADDR_HI(4'h2), .DEPTH_BIT(10), .READ_LATENCY(4), .WRITE_LATENCY(3)) dut1 (
    .i_clk(clk), .i_reset_n(rst_n), .i_addr(addr[1]), .i_read(rd[1]), .i_write(wr[1]),
    .i_write_sel(sel[1]), .i_write_data(wdata[1]), .o_data(odata[1]), .o_ack(ack[1]), .o_busy(busy[1]));

  rv_mem_slave #(.ADDR_HI(4'h0), .DEPTH_BIT(4), .READ_LATENCY(1), .WRITE_LATENCY(2)) dut2 (
    .i_clk(clk), .i_reset_n(rst_n), .i_addr(addr[2]), .i_read(rd[2]), .i_write(wr[2]),
    .i_write_sel(sel[2]), .i_write_data(wdata[2]), .o_data(odata[2]), .o_ack(ack[2]), .o_busy(busy[2]));

  // Transaction-level model: a pending transaction completes at an absolute cycle.
  logic [31:0] mmem [NI][1024];
  bit          mval [NI][1024];
  bit          m_active [NI];
  bit          m_inack  [NI];
  bit          m_wr     [NI];
  int          m_due    [NI];
  int          m_idx    [NI];
  logic [31:0] m_wd     [NI];
  logic [3:0]  m_sel    [NI];
  logic [31:0] e_data   [NI];
  bit          e_ack    [NI];
  bit          e_busy   [NI];
  bit          e_dval   [NI];

  function automatic void modelWrite(input int i);
    for (int b = 0; b < 4; b++)
      if (m_sel[i][b]) mmem[i][m_idx[i]][8*b +: 8] = m_wd[i][8*b +: 8];
    if (m_sel[i] == 4'hF) mval[i][m_idx[i]] = 1'b1;
  endfunction

  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < NI; i++) begin
      if (!rst_n) begin
        m_active[i] = 1'b0;
        m_inack[i]  = 1'b0;
      end else if (m_inack[i]) begin
        m_inack[i] = 1'b0;
      end else if (m_active[i]) begin
        if (!rd[i] && !wr[i]) begin
          m_active[i] = 1'b0;
        end else if (cyc == m_due[i]) begin
          if (m_wr[i]) modelWrite(i);
          m_active[i] = 1'b0;
          m_inack[i]  = 1'b1;
        end
      end else if ((rd[i] || wr[i]) && int'(addr[i][31:28]) == hi_p[i]) begin
        m_active[i] = 1'b1;
        m_wr[i]     = wr[i];
        m_due[i]    = cyc + (wr[i] ? wl_p[i] : rl_p[i]) + 1;
        m_idx[i]    = int'((addr[i] >> 2) & ((32'd1 << dep_p[i]) - 32'd1));
        m_wd[i]     = wdata[i];
        m_sel[i]    = sel[i];
      end
      e_ack[i]  = m_inack[i];
      e_busy[i] = m_active[i] || m_inack[i];
      e_data[i] = (m_inack[i] && !m_wr[i]) ? mmem[i][m_idx[i]] : 32'h0;
      e_dval[i] = !(m_inack[i] && !m_wr[i]) || mval[i][m_idx[i]];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (cyc > 0) begin
      for (int i = 0; i < NI; i++) begin
        checkOutput($sformatf("ack%0d", i), 32'(ack[i]), 32'(e_ack[i]));
        checkOutput($sformatf("busy%0d", i), 32'(busy[i]), 32'(e_busy[i]));
        if (e_dval[i]) checkOutput($sformatf("data%0d", i), odata[i], e_data[i]);
      end
    end
  end

  // hold==0: keep the request until ack (bounded); hold>0: drop after hold cycles.
  task automatic applyStimulus(input int i, input bit r, input bit w, input logic [31:0] a,
                               input logic [31:0] d, input logic [3:0] s, input int hold,
                               output int lat, output logic [31:0] data);
    int  start;
    bit  got;
    @(negedge clk);
    rd[i] = r; wr[i] = w; addr[i] = a; wdata[i] = d; sel[i] = s;
    start = cyc; got = 1'b0; lat = -1; data = 32'h0;
    if (hold == 0) begin
      for (int k = 0; k < 40 && !got; k++) begin
        @(negedge clk);
        if (k == 0) begin
          addr[i] = $urandom; wdata[i] = $urandom; sel[i] = 4'($urandom);
        end
        if (ack[i]) begin
          got  = 1'b1;
          lat  = cyc - (start + 1);
          data = odata[i];
        end
      end
      if (!got) checkOutput($sformatf("ack_timeout%0d", i), 32'd0, 32'd1);
    end else begin
      repeat (hold) @(negedge clk);
    end
    rd[i] = 1'b0; wr[i] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int          lat, a1, a2, idle_cyc;
    logic [31:0] data;
    bit          seen;
    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      rd[i] = 0; wr[i] = 0; addr[i] = 0; wdata[i] = 0; sel[i] = 0;
    end
    repeat (3) @(negedge clk);
    checkOutput("reset_ack", 32'(ack[0]), 32'd0);
    checkOutput("reset_busy", 32'(busy[0]), 32'd0);
    checkOutput("reset_data", odata[0], 32'h0);
    rst_n = 1'b1;

    // Full write then read
    applyStimulus(0, 0, 1, 32'h0000_0010, 32'hDEADBEEF, 4'hF, 0, lat, data);
    checkOutput("wr_latency", 32'(lat), 32'd2);
    applyStimulus(0, 1, 0, 32'h0000_0010, 32'h0, 4'h0, 0, lat, data);
    checkOutput("rd_latency", 32'(lat), 32'd3);
    checkOutput("rd_data", data, 32'hDEADBEEF);

    // Byte merge, with read and write both asserted on the second write
    applyStimulus(0, 0, 1, 32'h0000_0100, 32'h11223344, 4'hF, 0, lat, data);
    applyStimulus(0, 1, 1, 32'h0000_0100, 32'h0000AA00, 4'b0010, 0, lat, data);
    checkOutput("rdwr_as_write_lat", 32'(lat), 32'd2);
    applyStimulus(0, 1, 0, 32'h0000_0100, 32'h0, 4'h0, 0, lat, data);
    checkOutput("merge_data", data, 32'h1122AA44);
    checkOutput("model_merge", mmem[0][64], 32'h1122AA44);

    // Zero byte enables leave the word unchanged
    applyStimulus(0, 0, 1, 32'h0000_0100, 32'hFFFFFFFF, 4'h0, 0, lat, data);
    applyStimulus(0, 1, 0, 32'h0000_0100, 32'h0, 4'h0, 0, lat, data);
    checkOutput("sel0_data", data, 32'h1122AA44);

    // Decode miss
    @(negedge clk);
    rd[1] = 1'b1; addr[1] = 32'h3000_0000; seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen = seen | ack[1] | busy[1];
    end
    rd[1] = 1'b0;
    checkOutput("miss_quiet", 32'(seen), 32'd0);

    // Abort in the second WAIT cycle, then a normal request
    applyStimulus(1, 0, 1, 32'h2000_0008, 32'h0BADF00D, 4'hF, 0, lat, data);
    checkOutput("wr_latency1", 32'(lat), 32'd4);
    applyStimulus(1, 1, 0, 32'h2000_0008, 32'h0, 4'h0, 2, lat, data);
    @(negedge clk);
    checkOutput("abort_idle", 32'(busy[1]), 32'd0);
    applyStimulus(1, 1, 0, 32'h2000_0008, 32'h0, 4'h0, 0, lat, data);
    checkOutput("rd_latency1", 32'(lat), 32'd5);
    checkOutput("after_abort_data", data, 32'h0BADF00D);

    // Reset during the WAIT of a write
    applyStimulus(0, 0, 1, 32'h0000_0020, 32'h0, 4'hF, 0, lat, data);
    @(negedge clk);
    wr[0] = 1'b1; addr[0] = 32'h0000_0020; wdata[0] = 32'hCAFEF00D; sel[0] = 4'hF;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; wr[0] = 1'b0;
    checkOutput("rst_busy", 32'(busy[0]), 32'd0);
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      seen = seen | ack[0];
    end
    checkOutput("rst_no_ack", 32'(seen), 32'd0);
    applyStimulus(0, 1, 0, 32'h0000_0020, 32'h0, 4'h0, 0, lat, data);
    checkOutput("rst_mem_kept", data, 32'h0);

    // Address wrap on the 16-word slave
    applyStimulus(2, 0, 1, 32'h0000_0040, 32'h5A5A5A5A, 4'hF, 0, lat, data);
    checkOutput("wr_latency2", 32'(lat), 32'd3);
    applyStimulus(2, 1, 0, 32'h0000_0000, 32'h0, 4'h0, 0, lat, data);
    checkOutput("rd_latency2", 32'(lat), 32'd2);
    checkOutput("wrap_data", data, 32'h5A5A5A5A);

    // Held read becomes a second transaction with a full WAIT phase
    @(negedge clk);
    rd[0] = 1'b1; addr[0] = 32'h0000_0010; a1 = -1; a2 = -1; idle_cyc = 0;
    for (int k = 0; k < 40 && a2 < 0; k++) begin
      @(negedge clk);
      if (ack[0]) begin
        if (a1 < 0) a1 = cyc; else a2 = cyc;
      end
    end
    rd[0] = 1'b0;
    idle_cyc = a2 - a1;
    checkOutput("b2b_spacing", 32'(idle_cyc), 32'd5);

    // Random traffic
    for (int t = 0; t < 250; t++) begin
      int          i, kind, op, lt;
      logic [31:0] a;
      logic [3:0]  h;
      bit          r, w;
      i    = $urandom_range(0, NI - 1);
      kind = $urandom_range(0, 9);
      op   = $urandom_range(0, 2);
      r    = (op != 1);
      w    = (op != 0);
      lt   = w ? wl_p[i] : rl_p[i];
      a    = $urandom;
      a[31:28] = 4'(hi_p[i]);
      a[11:6]  = 6'h0;
      if (kind == 0) begin
        h = 4'(hi_p[i]) ^ 4'($urandom_range(1, 15));
        a[31:28] = h;
        applyStimulus(i, r, w, a, $urandom, 4'($urandom), $urandom_range(2, 6), lat, data);
      end else if (kind == 1) begin
        applyStimulus(i, r, w, a, $urandom, 4'($urandom), $urandom_range(1, lt), lat, data);
      end else if (kind == 2) begin
        @(negedge clk);
        rd[i] = r; wr[i] = w; addr[i] = a; wdata[i] = $urandom; sel[i] = 4'($urandom);
        repeat ($urandom_range(1, lt)) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; rd[i] = 1'b0; wr[i] = 1'b0;
      end else begin
        applyStimulus(i, r, w, a, $urandom, (op == 0) ? 4'h0 : 4'($urandom), 0, lat, data);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
